key_pulse_gen: RTL and testbench



---
 rtl/key_pulse_gen.sv | 87 ++++++++
 tb/tb_key_pulse_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: synchronised, debounced keys with one-clock press strobes; auto-repeat built only under KEY_AUTO_REPEAT_EN
module key_pulse_gen #(
  parameter int N = 7,
  parameter int TICK_DIV = 250000,
  parameter int DB_COUNT = 4,
  parameter int RPT_DELAY = 100,
  parameter int RPT_RATE = 20,
  parameter logic [N-1:0] RPT_MASK = 7'b1110000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] nKEY,
  output logic [N-1:0] PULSE,
  output logic [N-1:0] LEVEL
);
  localparam int TW = $clog2(TICK_DIV);
  logic [N-1:0] s1_q, s1_d, s2_q, s2_d, level_q, level_d, pulse_q, pulse_d;
  logic [N-1:0] p, hit, rise, fall, rpt;
  logic [N-1:0][3:0] db_q, db_d;
  logic [TW-1:0] tc_q, tc_d;
  logic tick;
  always_comb begin
    s1_d = nKEY;
    s2_d = s1_q;
    p = ~s2_q;
    tick = tc_q == TW'(TICK_DIV - 1);
    tc_d = tick ? '0 : tc_q + 1'b1;
    for (int i = 0; i < N; i++) begin
      hit[i] = tick && p[i] != level_q[i] && db_q[i] == 4'(DB_COUNT - 1);
      db_d[i] = !tick ? db_q[i] : (p[i] == level_q[i] || hit[i]) ? 4'd0 : db_q[i] + 4'd1;
    end
    level_d = level_q ^ hit;
    rise = level_d & ~level_q;
    fall = level_q & ~level_d;
  end
  assign pulse_d = rise | rpt;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_q <= '1;
      s2_q <= '1;
      tc_q <= '0;
      db_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      tc_q <= tc_d;
      db_q <= db_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end
  assign PULSE = pulse_q;
  assign LEVEL = level_q;
`ifdef KEY_AUTO_REPEAT_EN
  localparam int RMAX = RPT_DELAY > RPT_RATE ? RPT_DELAY : RPT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RPT} st_t;
  st_t st_q [N];
  st_t st_d [N];
  logic [RW-1:0] rc_q [N];
  logic [RW-1:0] rc_d [N];
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      st_q[i] <= !RST ? IDLE : st_d[i];
      rc_q[i] <= !RST ? '0 : rc_d[i];
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i] = fall[i] ? IDLE : rise[i] ? WAIT : rpt[i] ? RPT : st_q[i];
      rc_d[i] = (fall[i] || rise[i] || rpt[i]) ? '0 :
                (tick && RPT_MASK[i] && st_q[i] != IDLE && rc_q[i] != RW'(RMAX)) ? rc_q[i] + 1'b1 : rc_q[i];
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++)
      rpt[i] = RPT_MASK[i] && tick && !fall[i] && st_q[i] != IDLE &&
               int'(rc_q[i]) + 1 >= (st_q[i] == WAIT ? RPT_DELAY : RPT_RATE);
  end
`else
  logic unused_rpt_cfg;
  assign rpt = '0;
  assign unused_rpt_cfg = ^{RPT_MASK, RPT_DELAY[0], RPT_RATE[0]};
`endif
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed and random key stimulus against a tick-level behavioural model
module tb_key_pulse_gen;
  localparam int N = 7, TD = 4, DB = 3, RD = 5, RR = 2;
  localparam logic [N-1:0] MASK = 7'b1110000;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] nkey = '1, pulse, level;
  int checks = 0, errors = 0, cyc = 0;
  int pc [N];
  int first [N];
  logic [N-1:0] q1, q2, m_level, m_pulse;
  int ecnt;
  int run [N];
  int held [N];

  key_pulse_gen #(.N(N), .TICK_DIV(TD), .DB_COUNT(DB), .RPT_DELAY(RD), .RPT_RATE(RR), .RPT_MASK(MASK)) dut (
    .CLK(clk), .RST(rst), .nKEY(nkey), .PULSE(pulse), .LEVEL(level));

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [N-1:0] p;
    logic prev;
    bit tick;
    if (!rst) begin
      q1 = '1; q2 = '1; m_level = '0; m_pulse = '0; ecnt = 0;
      for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      p = ~q2;
      tick = (ecnt % TD) == TD - 1;
      m_pulse = '0;
      if (tick) for (int i = 0; i < N; i++) begin
        prev = m_level[i];
        if (p[i] != m_level[i]) begin
          run[i]++;
          if (run[i] == DB) begin run[i] = 0; m_level[i] = ~m_level[i]; end
        end else run[i] = 0;
        if (!prev && m_level[i]) begin m_pulse[i] = 1'b1; held[i] = 0; end
        else if (prev && m_level[i]) begin
          held[i]++;
          if (REP && MASK[i] && held[i] >= RD && (held[i] - RD) % RR == 0) m_pulse[i] = 1'b1;
        end
      end
      q2 = q1; q1 = nkey; ecnt++;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      pc[i] += int'(pulse[i]);
      if (pulse[i] && first[i] < 0) first[i] = cyc;
    end
    checks += 2;
    assert (pulse === m_pulse) else begin errors++; $error("FAIL %s pulse got %b exp %b", tag, pulse, m_pulse); end
    assert (level === m_level) else begin errors++; $error("FAIL %s level got %b exp %b", tag, level, m_level); end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin pc[i] = 0; first[i] = -1; end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  initial begin
    clr();
    rst = 1'b0; nkey = '0;
    repeat (3) step("reset");
    rst = 1'b1;
    repeat (11) step("post_reset");
    chk("no_early_strobe", pc[0] + pc[3] + pc[6], 0);
    repeat (4) step("all_pressed");
    chk("all_pressed_strobe0", pc[0], 1);
    chk("all_pressed_strobe6", pc[6], 1);
    nkey = '1;
    repeat (40) step("all_release");
    clr();
    nkey[0] = 1'b0;
    repeat (15) step("key0_press");
    chk("key0_within15", pc[0], 1);
    repeat (45) step("key0_hold");
    chk("key0_single", pc[0], 1);
    chk("key0_level", int'(level[0]), 1);
    nkey[0] = 1'b1;
    repeat (30) step("key0_release");
    clr();
    for (int k = 0; k < 16; k++) begin
      nkey[1] = ~nkey[1];
      repeat (3) step("key1_bounce");
    end
    nkey[1] = 1'b1;
    repeat (20) step("key1_settle");
    chk("key1_no_strobe", pc[1], 0);
    chk("key1_level", int'(level[1]), 0);
    clr();
    nkey[6] = 1'b0; nkey[0] = 1'b0;
    repeat (60) step("key6_repeat");
    chk("key6_strobes", pc[6], REP ? 5 : 1);
    chk("key0_with6", pc[0], 1);
    nkey = '1;
    repeat (30) step("key6_release");
    clr();
    nkey[3] = 1'b0; nkey[4] = 1'b0;
    repeat (20) step("key34_press");
    chk("key3_strobe", pc[3], 1);
    chk("key4_strobe", pc[4], 1);
    chk("key34_same_cycle", first[3], first[4]);
    nkey = '1;
    repeat (40) step("key34_release");
    chk("key34_cleared", int'(level[4:3]), 0);
    nkey[6] = 1'b0;
    repeat (40) step("key6_hold");
    rst = 1'b0;
    step("mid_reset");
    chk("mid_reset_pulse", int'(pulse), 0);
    chk("mid_reset_level", int'(level), 0);
    rst = 1'b1;
    clr();
    repeat (60) step("key6_after_reset");
    chk("key6_restart_strobes", pc[6], REP ? 5 : 1);
    nkey = '1;
    repeat (30) step("key6_final_release");
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) nkey[$urandom_range(0, N - 1)] ^= 1'b1;
      rst = (k == 300) ? 1'b0 : 1'b1;
      step("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
